// File: rtl/kws_wb_port.sv
// Wishbone classic slave feeding audio samples to the KWS core and capturing results.
// Optional frame counter at offset 0x14 is built when KWS_WB_FRAMECNT_EN is defined.
`timescale 1ns/1ps
module kws_wb_port #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK  = 32'h0000_00FF,
  parameter int          SAMPLE_W   = 16,
  parameter int          FIFO_DEPTH = 16,
  parameter int          RES_W      = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [SAMPLE_W-1:0] smp_data_o,
  output logic                smp_valid_o,
  input  logic                smp_ready_i,
  input  logic [RES_W-1:0]    res_data_i,
  input  logic                res_valid_i,
  output logic                irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS   = 32'h0000_0004;
  localparam logic [31:0] OFF_SAMPLE   = 32'h0000_0008;
  localparam logic [31:0] OFF_RESULT   = 32'h0000_000C;
  localparam logic [31:0] OFF_FRAMECNT = 32'h0000_0014;

  logic                enable;
  logic                irq_en;
  logic                overflow;
  logic                result_valid;
  logic [RES_W-1:0]    result;
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [8:0]          count9;
  logic [31:0]         frame_rd;
  logic [31:0]         rd_mux;

  logic        hit;
  logic [31:0] off;
  logic        acc;
  logic        wr;
  logic        rd;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        push_ok;
  logic        fifo_clr;

  assign hit  = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ~ADDR_MASK) == BASE_ADDR);
  assign off  = wbs_adr_i & ADDR_MASK;
  // The access commits at the end of the ack cycle, while the master still holds the request.
  assign acc  = wbs_ack_o & hit;
  assign wr   = acc & wbs_we_i & wbs_sel_i[0];
  assign rd   = acc & ~wbs_we_i;

  assign empty    = (count == {CW{1'b0}});
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = smp_valid_o & smp_ready_i;
  assign push     = wr & (off == OFF_SAMPLE);
  assign push_ok  = push & (~full | pop);
  assign fifo_clr = wr & (off == OFF_CTRL) & wbs_dat_i[1];
  assign count9   = 9'(count);

  assign smp_valid_o = enable & ~empty;
  assign smp_data_o  = empty ? {SAMPLE_W{1'b0}} : mem[rd_ptr];

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i, count9[8]};

  // Bus handshake: one-cycle ack per hit, read data presented alongside it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= hit & ~wbs_ack_o;
      wbs_dat_o <= (hit & ~wbs_ack_o & ~wbs_we_i) ? rd_mux : 32'h0;
    end
  end

  // Register read multiplexer.
  always_comb begin
    rd_mux = 32'h0;
    case (off)
      OFF_CTRL:     rd_mux = {29'h0, irq_en, 1'b0, enable};
      OFF_STATUS:   rd_mux = {16'h0, count9[7:0], 4'h0, overflow, result_valid, full, empty};
      OFF_RESULT:   rd_mux = 32'(result);
      OFF_FRAMECNT: rd_mux = frame_rd;
      default:      rd_mux = 32'h0;
    endcase
  end

  // Control and sticky overflow flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr && (off == OFF_CTRL)) begin
        enable <= wbs_dat_i[0];
        irq_en <= wbs_dat_i[2];
      end
      if (push & full & ~pop) begin
        overflow <= 1'b1;
      end else if (wr && (off == OFF_STATUS) && wbs_dat_i[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy; a clear overrides any concurrent pop.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || fifo_clr) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_ok, pop})
        2'b10:   count <= count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CW-1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // Sample storage; contents need no reset since the head output is gated by empty.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= wbs_dat_i[SAMPLE_W-1:0];
    end
  end

  // Result capture; a new result wins over the clear from a concurrent RESULT read.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      result       <= {RES_W{1'b0}};
      result_valid <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      if (res_valid_i) begin
        result       <= res_data_i;
        result_valid <= 1'b1;
      end else if (rd && (off == OFF_RESULT)) begin
        result_valid <= 1'b0;
      end
      irq_o <= irq_en & result_valid;
    end
  end

`ifdef KWS_WB_FRAMECNT_EN
  logic [31:0] frame_cnt;

  // Popped-sample counter, wrapping naturally at 2^32.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || fifo_clr) begin
      frame_cnt <= 32'h0;
    end else if (pop) begin
      frame_cnt <= frame_cnt + 32'h1;
    end
  end

  assign frame_rd = frame_cnt;
`else
  assign frame_rd = 32'h0;
`endif

endmodule

// File: tb/tb_kws_wb_port.sv
// Directed self-checking bench for kws_wb_port with default parameters.
`timescale 1ns/1ps
module tb_kws_wb_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [15:0] smp_data;
  logic        smp_valid, smp_ready;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        irq;

  int total = 0;
  int bad   = 0;

  kws_wb_port dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .smp_data_o(smp_data), .smp_valid_o(smp_valid), .smp_ready_i(smp_ready),
    .res_data_i(res_data), .res_valid_i(res_valid), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // One bus access, bounded at 8 cycles; optionally pulses a result during the ack cycle.
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, input logic inj, input logic [7:0] inj_d,
                     output logic [31:0] rdata, output logic acked);
    adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    acked = 1'b0; rdata = 32'h0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; rdata = dat_o; end
    end
    if (acked) begin
      if (inj) begin res_valid = 1'b1; res_data = inj_d; end
      @(posedge clk); #1;
      res_valid = 1'b0;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] r; logic k;
    bus(32'h3000_0000 | off, 1'b1, d, 4'hF, 1'b0, 8'h0, r, k);
    total++;
    if (k !== 1'b1) begin bad++; $display("FAIL wr_ack off=%h got=%b want=1", off, k); end
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] r);
    logic k;
    bus(32'h3000_0000 | off, 1'b0, 32'h0, 4'hF, 1'b0, 8'h0, r, k);
    total++;
    if (k !== 1'b1) begin bad++; $display("FAIL rd_ack off=%h got=%b want=1", off, k); end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ack, dat_o, smp_valid, smp_data, irq} !== 51'h0) begin
      bad++; $display("FAIL reset_outputs got ack=%b dat=%h v=%b d=%h irq=%b want all 0",
                      ack, dat_o, smp_valid, smp_data, irq);
    end
    rst = 1'b0;
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_0001) begin bad++; $display("FAIL reset_status got=%h want=00000001", r); end
  endtask

  task automatic test_stream();
    logic [31:0] r;
    wr(32'h00, 32'h1);
    wr(32'h08, 32'h0000_1234);
    wr(32'h08, 32'hFFFF_ABCD);
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_0200) begin bad++; $display("FAIL stream_level got=%h want=00000200", r); end
    total++;
    if (smp_data !== 16'h1234 || smp_valid !== 1'b1) begin
      bad++; $display("FAIL stream_head got=%h/%b want=1234/1", smp_data, smp_valid);
    end
    smp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (smp_data !== 16'hABCD || smp_valid !== 1'b1) begin
      bad++; $display("FAIL stream_second got=%h/%b want=abcd/1", smp_data, smp_valid);
    end
    @(posedge clk); #1;
    smp_ready = 1'b0;
    total++;
    if (smp_valid !== 1'b0) begin bad++; $display("FAIL stream_drained got=%b want=0", smp_valid); end
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_0001) begin bad++; $display("FAIL stream_empty got=%h want=00000001", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    for (int i = 0; i < 17; i++) wr(32'h08, 32'd100 + 32'(i));
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_100A) begin bad++; $display("FAIL ovf_status got=%h want=0000100a", r); end
    total++;
    if (smp_data !== 16'h0064) begin bad++; $display("FAIL ovf_head got=%h want=0064", smp_data); end
    wr(32'h04, 32'h8);
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_1002) begin bad++; $display("FAIL ovf_clear got=%h want=00001002", r); end
    wr(32'h00, 32'h3);
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_0001) begin bad++; $display("FAIL fifo_clear got=%h want=00000001", r); end
    rd(32'h00, r);
    total++;
    if (r !== 32'h0000_0001) begin bad++; $display("FAIL ctrl_read got=%h want=00000001", r); end
  endtask

  task automatic test_sel();
    logic [31:0] r; logic k;
    bus(32'h3000_0000, 1'b1, 32'h4, 4'hE, 1'b0, 8'h0, r, k);
    rd(32'h00, r);
    total++;
    if (r !== 32'h0000_0001 || k !== 1'b1) begin
      bad++; $display("FAIL sel0_gate got=%h ack=%b want=00000001 ack=1", r, k);
    end
  endtask

  task automatic test_result();
    logic [31:0] r; logic k;
    wr(32'h00, 32'h4);
    res_data = 8'h2A; res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_delay got=%b want=0", irq); end
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want=1", irq); end
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_0005) begin bad++; $display("FAIL res_status got=%h want=00000005", r); end
    rd(32'h0C, r);
    total++;
    if (r !== 32'h0000_002A || irq !== 1'b1) begin
      bad++; $display("FAIL res_read got=%h irq=%b want=0000002a irq=1", r, irq);
    end
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b want=0", irq); end
    // A new result arriving with a RESULT read keeps result_valid set.
    res_data = 8'h33; res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    bus(32'h3000_000C, 1'b0, 32'h0, 4'hF, 1'b1, 8'h77, r, k);
    total++;
    if (r !== 32'h0000_0033 || k !== 1'b1) begin
      bad++; $display("FAIL res_race_old got=%h ack=%b want=00000033 ack=1", r, k);
    end
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_0005) begin bad++; $display("FAIL res_race_valid got=%h want=00000005", r); end
    rd(32'h0C, r);
    total++;
    if (r !== 32'h0000_0077) begin bad++; $display("FAIL res_race_new got=%h want=00000077", r); end
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_0001) begin bad++; $display("FAIL res_cleared got=%h want=00000001", r); end
  endtask

  task automatic test_window();
    logic [31:0] r; logic k; logic [5:0] pat;
    bus(32'h3000_0100, 1'b0, 32'h0, 4'hF, 1'b0, 8'h0, r, k);
    total++;
    if (k !== 1'b0) begin bad++; $display("FAIL out_of_window got ack=%b want=0", k); end
    bus(32'h3000_0020, 1'b0, 32'h0, 4'hF, 1'b0, 8'h0, r, k);
    total++;
    if (k !== 1'b1 || r !== 32'h0) begin
      bad++; $display("FAIL unmapped got ack=%b dat=%h want ack=1 dat=0", k, r);
    end
    adr = 32'h3000_0004; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      @(posedge clk); #1;
      pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    total++;
    if (pat !== 6'b101010) begin bad++; $display("FAIL held_stb got=%b want=101010", pat); end
  endtask

  task automatic test_framecnt();
    logic [31:0] r; logic [31:0] exp5;
`ifdef KWS_WB_FRAMECNT_EN
    exp5 = 32'd5;
`else
    exp5 = 32'd0;
`endif
    wr(32'h00, 32'h2);
    for (int i = 0; i < 5; i++) wr(32'h08, 32'(i + 1));
    smp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_0500) begin bad++; $display("FAIL retain_disabled got=%h want=00000500", r); end
    wr(32'h00, 32'h1);
    repeat (8) @(posedge clk);
    #1;
    smp_ready = 1'b0;
    rd(32'h04, r);
    total++;
    if (r !== 32'h0000_0001) begin bad++; $display("FAIL drain5 got=%h want=00000001", r); end
    rd(32'h14, r);
    total++;
    if (r !== exp5) begin bad++; $display("FAIL framecnt got=%h want=%h", r, exp5); end
    wr(32'h00, 32'h3);
    rd(32'h14, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL framecnt_clear got=%h want=0", r); end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_i = 32'h0; smp_ready = 1'b0; res_data = 8'h0; res_valid = 1'b0;
    test_reset();
    test_stream();
    test_overflow();
    test_sel();
    test_result();
    test_window();
    test_framecnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
